// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- pipeline-to-hazard-unit signal bundle.
//   master : pipeline side (drives ID/EX/MEM status, receives stage controls)
//   slave  : hazard_ctrl side
// Status  : if_id_rs, if_id_rt, uses_rt, id_ex_mem_read, id_ex_rt,
//           branch_taken, mem_busy
// Control : inhibit_control, pc_write_en, if_id_write_en, if_id_flush,
//           id_ex_write_en
interface hazard_ctrl_if;
   logic [4:0] if_id_rs;
   logic [4:0] if_id_rt;
   logic       uses_rt;
   logic       id_ex_mem_read;
   logic [4:0] id_ex_rt;
   logic       branch_taken;
   logic       mem_busy;

   logic       inhibit_control;
   logic       pc_write_en;
   logic       if_id_write_en;
   logic       if_id_flush;
   logic       id_ex_write_en;

   modport master (
      output if_id_rs, if_id_rt, uses_rt, id_ex_mem_read, id_ex_rt,
             branch_taken, mem_busy,
      input  inhibit_control, pc_write_en, if_id_write_en, if_id_flush,
             id_ex_write_en
   );

   modport slave (
      input  if_id_rs, if_id_rt, uses_rt, id_ex_mem_read, id_ex_rt,
             branch_taken, mem_busy,
      output inhibit_control, pc_write_en, if_id_write_en, if_id_flush,
             id_ex_write_en
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- load-use stall, taken-branch flush and memory-freeze
// controller for a 5-stage pipeline, with a sticky memory watchdog.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : pipeline status in, stage enables / bubble / flush out
//   mem_timeout  : sticky flag, mem_busy held longer than FREEZE_MAX cycles
//   stall_cnt    : count of load-use stall cycles (CNT_W bits)
//   flush_cnt    : count of taken-branch flush cycles (CNT_W bits)
// Parameters: FREEZE_MAX (1..255), CNT_W.
// Optional feature: define HAZARD_PERF_CNT_EN to build the performance
// counters; otherwise stall_cnt/flush_cnt are tied to zero.
// Stage controls are combinational on the current inputs so a stall, flush
// or freeze takes effect in the cycle it is detected.
module hazard_ctrl #(
   parameter int unsigned FREEZE_MAX = 15,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   hazard_ctrl_if.slave     bus,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [7:0] FMAX = 8'(FREEZE_MAX);

   typedef enum logic [1:0] {RUN, STALL, FLUSH, FREEZE} state_t;

   state_t     state;
   state_t     state_nxt;
   logic       hazard;
   logic       br_pend;
   logic       br_eff;
   logic       do_stall;
   logic       do_flush;
   logic [7:0] frz_cnt;

   always_comb begin
      hazard = bus.id_ex_mem_read && (bus.id_ex_rt != 5'd0) &&
               ((bus.id_ex_rt == bus.if_id_rs) ||
                (bus.uses_rt && (bus.id_ex_rt == bus.if_id_rt)));
      // A branch seen while frozen is held until memory releases the pipe.
      br_eff   = bus.branch_taken || br_pend;
      do_flush = !bus.mem_busy && br_eff;
      // Hazard is only honoured from RUN (or FREEZE, which resumes RUN);
      // STALL/FLUSH ignore it, bounding each load to one bubble.
      do_stall = !bus.mem_busy && !br_eff && hazard &&
                 ((state == RUN) || (state == FREEZE));

      if (bus.mem_busy)  state_nxt = FREEZE;
      else if (do_flush) state_nxt = FLUSH;
      else if (do_stall) state_nxt = STALL;
      else               state_nxt = RUN;

      bus.pc_write_en     = 1'b1;
      bus.if_id_write_en  = 1'b1;
      bus.id_ex_write_en  = 1'b1;
      bus.inhibit_control = 1'b0;
      bus.if_id_flush     = 1'b0;
      if (rst) begin
         bus.pc_write_en     = 1'b0;
         bus.if_id_write_en  = 1'b0;
         bus.id_ex_write_en  = 1'b0;
         bus.inhibit_control = 1'b1;
      end else if (bus.mem_busy) begin
         bus.pc_write_en    = 1'b0;
         bus.if_id_write_en = 1'b0;
         bus.id_ex_write_en = 1'b0;
      end else if (do_flush) begin
         bus.if_id_flush     = 1'b1;
         bus.inhibit_control = 1'b1;
      end else if (do_stall) begin
         bus.pc_write_en     = 1'b0;
         bus.if_id_write_en  = 1'b0;
         bus.inhibit_control = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         br_pend     <= 1'b0;
         frz_cnt     <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         br_pend <= bus.mem_busy && (br_pend || bus.branch_taken);
         if (!bus.mem_busy) begin
            frz_cnt <= '0;
         end else if (frz_cnt == FMAX) begin
            mem_timeout <= 1'b1;
         end else begin
            frz_cnt <= frz_cnt + 8'd1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (do_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (do_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl. Expected control
// vectors are queued as each stimulus row is driven and compared when the
// outputs are sampled on the following falling edge.
module tb_hazard_ctrl;

   localparam int unsigned CNT_W = 16;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {pc_write_en, if_id_write_en, id_ex_write_en, inhibit_control, if_id_flush}
   localparam logic [4:0] O_IDLE  = 5'b11100;
   localparam logic [4:0] O_RST   = 5'b00010;
   localparam logic [4:0] O_STALL = 5'b00110;
   localparam logic [4:0] O_FLUSH = 5'b11111;
   localparam logic [4:0] O_FRZ   = 5'b00000;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       ur;
      logic       mr;
      logic [4:0] ert;
      logic       br;
      logic       busy;
      logic [4:0] exp;
   } row_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   hazard_ctrl_if bus();

   hazard_ctrl #(.FREEZE_MAX(15), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned exp_stall = 0;
   int unsigned exp_flush = 0;
   logic [4:0]  exp_q[$];

   function automatic row_t mk(input int rs, input int rt, input bit ur,
                               input bit mr, input int ert, input bit br,
                               input bit busy, input logic [4:0] exp);
      row_t r;
      r.rs = 5'(rs); r.rt = 5'(rt); r.ur = ur; r.mr = mr;
      r.ert = 5'(ert); r.br = br; r.busy = busy; r.exp = exp;
      return r;
   endfunction

   function automatic logic [4:0] outs();
      return {bus.pc_write_en, bus.if_id_write_en, bus.id_ex_write_en,
              bus.inhibit_control, bus.if_id_flush};
   endfunction

   function automatic logic [CNT_W-1:0] want(input int unsigned n);
      return PERF ? CNT_W'(n) : '0;
   endfunction

   task automatic drive(input row_t r);
      @(posedge clk); #1;
      bus.if_id_rs = r.rs; bus.if_id_rt = r.rt; bus.uses_rt = r.ur;
      bus.id_ex_mem_read = r.mr; bus.id_ex_rt = r.ert;
      bus.branch_taken = r.br; bus.mem_busy = r.busy;
      exp_q.push_back(r.exp);
      if (r.exp == O_STALL) exp_stall++;
      if (r.exp == O_FLUSH) exp_flush++;
   endtask

   task automatic test_reset();
      logic [4:0] e;
      @(negedge clk);
      n_cmp++;
      if (outs() !== O_RST) begin
         n_err++; $display("FAIL reset_outs: got %b expected %b", outs(), O_RST);
      end
      n_cmp++;
      if (mem_timeout !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
         n_err++;
         $display("FAIL reset_regs: got to=%b s=%0d f=%0d expected 0 0 0",
                  mem_timeout, stall_cnt, flush_cnt);
      end
      @(posedge clk); #1 rst = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (outs() !== e) begin
         n_err++; $display("FAIL reset_release: got %b expected %b", outs(), e);
      end
   endtask

   task automatic run_rows(input string name, input row_t t[$]);
      logic [4:0] e;
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (outs() !== e) begin
            n_err++;
            $display("FAIL %s[%0d]: got %b expected %b", name, i, outs(), e);
         end
      end
   endtask

   task automatic test_load_use();
      row_t t[$];
      t.push_back(mk(5, 0, 0, 1, 5, 0, 0, O_STALL));
      t.push_back(mk(5, 0, 0, 1, 5, 0, 0, O_IDLE));   // second cycle: no extra bubble
      t.push_back(mk(5, 0, 0, 0, 0, 0, 0, O_IDLE));
      run_rows("load_use", t);
      n_cmp++;
      if (stall_cnt !== want(exp_stall)) begin
         n_err++;
         $display("FAIL load_use_cnt: got %0d expected %0d", stall_cnt, want(exp_stall));
      end
   endtask

   task automatic test_zero_and_rt();
      row_t t[$];
      t.push_back(mk(0, 0, 1, 1, 0, 0, 0, O_IDLE));   // $zero never stalls
      t.push_back(mk(3, 7, 0, 1, 7, 0, 0, O_IDLE));   // rt match, rt unused
      t.push_back(mk(3, 7, 1, 1, 7, 0, 0, O_STALL));  // rt match, rt used
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE));
      run_rows("zero_rt", t);
      n_cmp++;
      if (stall_cnt !== want(exp_stall)) begin
         n_err++;
         $display("FAIL zero_rt_cnt: got %0d expected %0d", stall_cnt, want(exp_stall));
      end
   endtask

   task automatic test_branch();
      row_t t[$];
      t.push_back(mk(0, 0, 0, 0, 0, 1, 0, O_FLUSH));
      t.push_back(mk(9, 0, 0, 1, 9, 0, 0, O_IDLE));   // hazard after flush ignored
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE));
      t.push_back(mk(4, 0, 0, 1, 4, 1, 0, O_FLUSH));  // branch beats hazard
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE));
      run_rows("branch", t);
      n_cmp++;
      if (flush_cnt !== want(exp_flush) || stall_cnt !== want(exp_stall)) begin
         n_err++;
         $display("FAIL branch_cnt: got f=%0d s=%0d expected f=%0d s=%0d",
                  flush_cnt, stall_cnt, want(exp_flush), want(exp_stall));
      end
   endtask

   task automatic test_freeze();
      row_t t[$];
      t.push_back(mk(0, 0, 0, 0, 0, 1, 1, O_FRZ));    // branch during freeze
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, O_FRZ));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_FLUSH));  // latched branch acts
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE));
      t.push_back(mk(6, 0, 0, 1, 6, 0, 1, O_FRZ));    // busy beats hazard
      t.push_back(mk(6, 0, 0, 1, 6, 0, 0, O_STALL));  // FREEZE resumes RUN rules
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE));
      run_rows("freeze", t);
      n_cmp++;
      if (flush_cnt !== want(exp_flush) || stall_cnt !== want(exp_stall)) begin
         n_err++;
         $display("FAIL freeze_cnt: got f=%0d s=%0d expected f=%0d s=%0d",
                  flush_cnt, stall_cnt, want(exp_flush), want(exp_stall));
      end
   endtask

   task automatic test_watchdog();
      row_t t[$];
      for (int i = 0; i < 15; i++) t.push_back(mk(0, 0, 0, 0, 0, 0, 1, O_FRZ));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE));
      run_rows("wd15", t);
      n_cmp++;
      if (mem_timeout !== 1'b0) begin
         n_err++; $display("FAIL wd15_timeout: got %b expected 0", mem_timeout);
      end
      t.delete();
      for (int i = 0; i < 16; i++) t.push_back(mk(0, 0, 0, 0, 0, 0, 1, O_FRZ));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE));
      run_rows("wd16", t);
      n_cmp++;
      if (mem_timeout !== 1'b1) begin
         n_err++; $display("FAIL wd16_timeout: got %b expected 1", mem_timeout);
      end
      t.delete();
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE));
      run_rows("wd_idle", t);
      n_cmp++;
      if (mem_timeout !== 1'b1) begin
         n_err++; $display("FAIL wd_sticky: got %b expected 1", mem_timeout);
      end
   endtask

   task automatic test_reset_in_stall();
      row_t t[$];
      t.push_back(mk(8, 0, 0, 1, 8, 0, 0, O_STALL));
      run_rows("rst_stall_pre", t);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      n_cmp++;
      if (outs() !== O_RST) begin
         n_err++; $display("FAIL rst_async_outs: got %b expected %b", outs(), O_RST);
      end
      n_cmp++;
      if (mem_timeout !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
         n_err++;
         $display("FAIL rst_async_regs: got to=%b s=%0d f=%0d expected 0 0 0",
                  mem_timeout, stall_cnt, flush_cnt);
      end
      exp_stall = 0;
      exp_flush = 0;
      @(posedge clk); #1 rst = 1'b0;
      t.delete();
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE));
      t.push_back(mk(8, 0, 0, 1, 8, 0, 0, O_STALL));  // stall accepted: state is RUN
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE));
      run_rows("rst_stall_post", t);
      n_cmp++;
      if (stall_cnt !== want(exp_stall)) begin
         n_err++;
         $display("FAIL rst_stall_cnt: got %0d expected %0d", stall_cnt, want(exp_stall));
      end
   endtask

   initial begin
      bus.if_id_rs = '0; bus.if_id_rt = '0; bus.uses_rt = 1'b0;
      bus.id_ex_mem_read = 1'b0; bus.id_ex_rt = '0;
      bus.branch_taken = 1'b0; bus.mem_busy = 1'b0;
      test_reset();
      test_load_use();
      test_zero_and_rt();
      test_branch();
      test_freeze();
      test_watchdog();
      test_reset_in_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

endmodule
